adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 105 ++++++++++
 tb/tb_adder_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit adder among NUM_REQ requesters.
// A granted request is registered and its sum is presented on rsp_* one cycle later.
module adder_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_opa_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_opb_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [IDW-1:0]                    rsp_id_o,
    output logic [WIDTH-1:0]                  rsp_sum_o,
    output logic                              rsp_carry_o
);

    // Valid/ready: a transfer happens on a port in any cycle where both its
    // valid and ready are high at the rising edge of clk_i.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;

    logic             accept;
    logic             found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic             gnt_valid;
    logic [WIDTH:0]   sum_w;

    // Window is closed while reset is asserted so no requester sees a grant.
    assign accept    = !rst_i && ((state_q == S_IDLE) || rsp_ready_i);
    assign gnt_valid = accept && found;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (gnt_valid) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        if (gnt_valid) begin
            state_d = S_HOLD;
            id_d    = gnt_idx;
            opa_d   = req_opa_i[gnt_idx];
            opb_d   = req_opb_i[gnt_idx];
            ptr_d   = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == S_HOLD && rsp_ready_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    assign sum_w       = {1'b0, opa_q} + {1'b0, opb_q};
    assign rsp_valid_o = (state_q == S_HOLD);
    assign rsp_id_o    = id_q;
    assign rsp_sum_o   = sum_w[WIDTH-1:0];
    assign rsp_carry_o = sum_w[WIDTH];

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed bench for adder_arbiter (WIDTH=8, NUM_REQ=4) with a
// queue-based reference of granted operations checked every cycle.
module tb_adder_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int RW  = IDW + 1 + W;

    logic                   clk;
    logic                   rst;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][W-1:0]    req_opa;
    logic [N-1:0][W-1:0]    req_opb;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [W-1:0]           rsp_sum;
    logic                   rsp_carry;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state: results owed to the consumer, in order
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] last_res;
    int            ptr;

    adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_opa_i   (req_opa),
        .req_opb_i   (req_opb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum),
        .rsp_carry_o (rsp_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = v >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Apply one cycle of inputs, compare outputs mid-cycle, advance the model.
    task automatic step(input logic r, input logic [N-1:0] v, input logic rr);
        int            g;
        int            s;
        logic [N-1:0]  exp_ready;
        logic [RW-1:0] cur;
        logic [RW-1:0] res;
        logic [31:0]   sv;
        rst       = r;
        req_valid = v;
        rsp_ready = rr;
        @(negedge clk);
        g = -1;
        if (!r && (exp_q.size() == 0 || rr)) g = pick(v, ptr);
        exp_ready = '0;
        if (g >= 0) exp_ready = N'(1) << g;
        cur = (exp_q.size() > 0) ? exp_q[0] : last_res;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
        check("rsp_id",    32'(rsp_id),    32'(cur[RW-1 -: IDW]));
        check("rsp_carry", 32'(rsp_carry), 32'(cur[W]));
        check("rsp_sum",   32'(rsp_sum),   32'(cur[W-1:0]));
        if (r) begin
            exp_q.delete();
            last_res = '0;
            ptr      = 0;
        end else begin
            if (exp_q.size() > 0 && rr) last_res = exp_q.pop_front();
            if (g >= 0) begin
                s   = int'(req_opa[g]) + int'(req_opb[g]);
                sv  = 32'(s);
                res = {IDW'(g), (s > 255) ? 1'b1 : 1'b0, sv[W-1:0]};
                exp_q.push_back(res);
                ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_opa[i] = a;
        req_opb[i] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_opa[i] = W'($urandom_range(0, 255));
            req_opb[i] = W'($urandom_range(0, 255));
        end
    endtask

    initial begin
        last_res  = '0;
        ptr       = 0;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        rand_ops();
        repeat (2) @(posedge clk);
        #1;

        // reset state, with requests present that must not be granted
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'h5, 1'b0);

        // single request from requester 2
        set_op(2, 8'h12, 8'h34);
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        // overflow cases on requester 0
        set_op(0, 8'hFF, 8'h01);
        step(1'b0, 4'b0001, 1'b1);
        set_op(0, 8'h80, 8'h80);
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        // reset, then round-robin with everyone requesting
        step(1'b1, 4'h0, 1'b0);
        for (int c = 0; c < 9; c++) begin
            rand_ops();
            step(1'b0, 4'hF, 1'b1);
        end

        // backpressure: five stalled cycles, then release
        for (int c = 0; c < 5; c++) begin
            rand_ops();
            step(1'b0, 4'hF, 1'b0);
        end
        step(1'b0, 4'hF, 1'b1);
        step(1'b0, 4'h0, 1'b1);

        // wrap and skip: ptr to 3 via requester 2, then only requester 1
        step(1'b1, 4'h0, 1'b0);
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0010, 1'b1);
        step(1'b0, 4'hF, 1'b1);
        step(1'b0, 4'h0, 1'b1);

        // reset while holding a result, then a normal request from requester 0
        step(1'b0, 4'b1000, 1'b0);
        step(1'b1, 4'hF, 1'b1);
        step(1'b0, 4'h0, 1'b0);
        set_op(0, 8'h21, 8'h43);
        step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b1);

        // random traffic; operands also change while requests wait ungranted
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 N'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
